// File: rtl/borrow_lookahead_subtractor_seq.sv
// -----------------------------------------------------------------------------
// borrow_lookahead_subtractor_seq
//
// Sequential subtractor: diff = a - b - bin (mod 2^WIDTH), one 4-bit slice per
// clock, least significant slice first. Each slice uses a fully expanded
// borrow-lookahead network (g = ~a & b, p = ~(a ^ b)). The slice borrow-out is
// registered and feeds the next slice on the following cycle.
//
// Handshakes (valid/ready): a transfer happens on a rising clk edge where
// valid and ready are both high. The producer holds valid and its data until
// that edge. Ready never depends combinationally on valid.
//   input side : in_valid/in_ready; in_ready is high only in IDLE.
//   output side: out_valid/out_ready; out_valid is high only in DONE, and
//                diff/bout/zero (and ovf) are held stable while it is high.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   in_valid   operands offered         in_ready  block can accept operands
//   a, b       minuend / subtrahend     bin       borrow-in
//   out_valid  result valid             out_ready consumer accepts result
//   diff       a - b - bin              bout      final borrow (a < b + bin)
//   zero       diff == 0
//   ovf        signed overflow (only with BLA_SUB_SIGNED_OVF_EN defined)
//
// Optional feature macro: BLA_SUB_SIGNED_OVF_EN
// Latency: out_valid rises NSLICE cycles after the accept edge.
// -----------------------------------------------------------------------------
module borrow_lookahead_subtractor_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             zero
`ifdef BLA_SUB_SIGNED_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int NSLICE = WIDTH / 4;
  localparam int KW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [KW-1:0] KLAST = KW'(NSLICE - 1);

  if ((WIDTH % 4) != 0 || WIDTH < 4) begin : g_width_check
    $fatal(1, "borrow_lookahead_subtractor_seq: WIDTH must be a multiple of 4 and >= 4");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [WIDTH-1:0] a_q, b_q, diff_q, diff_nxt;
  logic             borrow_q, bout_q, zero_q;
  logic [KW-1:0]    k_q;
  logic             accept, last;

  // Slice datapath signals
  logic [KW+1:0]    base;
  logic [3:0]       as, bs, g, p, d;
  logic [4:0]       bc;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // ---------------------------------------------------------------------------
  // FSM: next state and handshake outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    accept    = 1'b0;
    last      = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept  = 1'b1;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (k_q == KLAST) begin
          last    = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Current slice: expanded borrow lookahead, no ripple between bits.
  // ---------------------------------------------------------------------------
  always_comb begin
    base  = {k_q, 2'b00};
    as    = a_q[base +: 4];
    bs    = b_q[base +: 4];
    g     = ~as & bs;
    p     = ~(as ^ bs);
    bc[0] = borrow_q;
    bc[1] = g[0] | (p[0] & bc[0]);
    bc[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & bc[0]);
    bc[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
          | (p[2] & p[1] & p[0] & bc[0]);
    bc[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
          | (p[3] & p[2] & p[1] & g[0])
          | (p[3] & p[2] & p[1] & p[0] & bc[0]);
    d     = as ^ bs ^ bc[3:0];
    diff_nxt = diff_q;
    diff_nxt[base +: 4] = d;
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q      <= '0;
      b_q      <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      bout_q   <= 1'b0;
      zero_q   <= 1'b0;
      k_q      <= '0;
    end else if (accept) begin
      a_q      <= a;
      b_q      <= b;
      borrow_q <= bin;
      k_q      <= '0;
    end else if (state_q == BUSY) begin
      diff_q   <= diff_nxt;
      borrow_q <= bc[4];
      k_q      <= k_q + KW'(1);
      if (last) begin
        // Flags are taken from the completed result so they appear
        // together with out_valid.
        bout_q <= bc[4];
        zero_q <= (diff_nxt == '0);
      end
    end
  end

  assign diff = diff_q;
  assign bout = bout_q;
  assign zero = zero_q;

`ifdef BLA_SUB_SIGNED_OVF_EN
  logic ovf_q;
  // Sign bits come from the latched operands; a_q/b_q are not modified
  // while BUSY, so the top bits are still the original operand signs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ovf_q <= 1'b0;
    else if (state_q == BUSY && last)
      ovf_q <= (a_q[WIDTH-1] ^ b_q[WIDTH-1]) & (a_q[WIDTH-1] ^ diff_nxt[WIDTH-1]);
  end
  assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_borrow_lookahead_subtractor_seq.sv
// -----------------------------------------------------------------------------
// Bench for borrow_lookahead_subtractor_seq (WIDTH = 16). Expected results
// come from plain integer subtraction; inputs are driven on the falling edge
// and outputs sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_borrow_lookahead_subtractor_seq;

  localparam int W      = 16;
  localparam int NSLICE = W / 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         bin = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] diff;
  logic         bout;
  logic         zero;
`ifdef BLA_SUB_SIGNED_OVF_EN
  logic         ovf;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  // Scoreboard: {bout, diff} and the signed-overflow flag per accepted op.
  logic [W:0] exp_q[$];
  logic       exp_ovf_q[$];

  borrow_lookahead_subtractor_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .bout      (bout),
    .zero      (zero)
`ifdef BLA_SUB_SIGNED_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  // Clock
  always #5 clk = ~clk;

  // Reference model: unsigned and signed integer arithmetic.
  task automatic model_push(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                            input logic tbin);
    logic [W:0] full;
    int         sr;
    full = {1'b0, ta} - {1'b0, tb_v} - {{W{1'b0}}, tbin};
    exp_q.push_back(full);
    sr = int'($signed(ta)) - int'($signed(tb_v)) - int'(tbin);
    exp_ovf_q.push_back((sr > 32767) || (sr < -32768));
  endtask

  // One full transaction: accept, wait for result, check, optional
  // backpressure, retire. Called at a falling edge with the DUT in IDLE.
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                        input logic tbin, input int hold);
    logic [W:0] e;
    logic       e_ovf;
    int         cyc;
    model_push(ta, tb_v, tbin);
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL in_ready_idle: got %b expected 1", in_ready);
    end
    in_valid = 1'b1; a = ta; b = tb_v; bin = tbin;
    @(posedge clk);
    @(negedge clk);
    // Operands must be ignored after the accept edge.
    in_valid = 1'b0;
    a = W'($urandom_range(0, 65535));
    b = W'($urandom_range(0, 65535));
    bin = 1'($urandom_range(0, 1));
    n_cmp++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL busy_handshake: got in_ready=%b out_valid=%b expected 0/0",
               in_ready, out_valid);
    end
    cyc = 0;
    while (out_valid !== 1'b1 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    e     = exp_q.pop_front();
    e_ovf = exp_ovf_q.pop_front();
    n_cmp++;
    if (cyc != NSLICE) begin
      n_fail++;
      $display("FAIL latency: got %0d cycles expected %0d", cyc, NSLICE);
    end
    if (out_valid !== 1'b1) return;
    n_cmp++;
    if (diff !== e[W-1:0] || bout !== e[W] || zero !== (e[W-1:0] == '0)) begin
      n_fail++;
      $display("FAIL result a=%h b=%h bin=%b: got diff=%h bout=%b zero=%b expected diff=%h bout=%b zero=%b",
               ta, tb_v, tbin, diff, bout, zero, e[W-1:0], e[W], (e[W-1:0] == '0));
    end
`ifdef BLA_SUB_SIGNED_OVF_EN
    n_cmp++;
    if (ovf !== e_ovf) begin
      n_fail++;
      $display("FAIL ovf a=%h b=%h bin=%b: got %b expected %b", ta, tb_v, tbin, ovf, e_ovf);
    end
`endif
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      a = W'($urandom_range(0, 65535));
      b = W'($urandom_range(0, 65535));
      @(negedge clk);
      n_cmp++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || diff !== e[W-1:0] ||
          bout !== e[W] || zero !== (e[W-1:0] == '0)) begin
        n_fail++;
        $display("FAIL backpressure_hold cyc %0d: got ov=%b ir=%b diff=%h bout=%b zero=%b expected ov=1 ir=0 diff=%h bout=%b",
                 i, out_valid, in_ready, diff, bout, zero, e[W-1:0], e[W]);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL retire: got out_valid=%b in_ready=%b expected 0/1", out_valid, in_ready);
    end
  endtask

  task automatic check_reset_values(input string name);
    n_cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || diff !== '0 ||
        bout !== 1'b0 || zero !== 1'b0) begin
      n_fail++;
      $display("FAIL %s: got ir=%b ov=%b diff=%h bout=%b zero=%b expected ir=1 ov=0 diff=0 bout=0 zero=0",
               name, in_ready, out_valid, diff, bout, zero);
    end
`ifdef BLA_SUB_SIGNED_OVF_EN
    n_cmp++;
    if (ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_ovf: got %b expected 0", name, ovf);
    end
`endif
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_values("reset_state");
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    run_op(16'h1234, 16'h0234, 1'b0, 0);
    run_op(16'h00FF, 16'h000F, 1'b0, 0);
  endtask

  task automatic test_borrow_chain();
    run_op(16'h1000, 16'h0001, 1'b0, 0);
    run_op(16'h0000, 16'h0001, 1'b0, 0);
  endtask

  task automatic test_bin_zero();
    run_op(16'h0005, 16'h0004, 1'b1, 0);
    run_op(16'h0000, 16'h0000, 1'b1, 0);
    run_op(16'hABCD, 16'hABCD, 1'b0, 0);
  endtask

  task automatic test_backpressure();
    run_op(16'hC0DE, 16'h1234, 1'b1, 5);
  endtask

  task automatic test_reset_mid();
    // Leave a nonzero result behind so the reset clear is observable.
    run_op(16'h8765, 16'h0123, 1'b0, 0);
    in_valid = 1'b1; a = 16'h1234; b = 16'h0001; bin = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1 check_reset_values("reset_mid_busy");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_op(16'hFFFF, 16'h0001, 1'b0, 0);
  endtask

  task automatic test_ovf();
    run_op(16'h8000, 16'h0001, 1'b0, 0);
    run_op(16'h7FFF, 16'h0001, 1'b0, 0);
    run_op(16'h0000, 16'h8000, 1'b0, 0);
    run_op(16'h7FFF, 16'hFFFF, 1'b0, 0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      run_op(W'($urandom_range(0, 65535)), W'($urandom_range(0, 65535)),
             1'($urandom_range(0, 1)), int'($urandom_range(0, 2)));
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_borrow_chain();
    test_bin_zero();
    test_backpressure();
    test_reset_mid();
    test_ovf();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
